// File: rtl/xnor_match_pkg.sv
// Shared definitions for xnor_match_acc: FSM encoding, compare-mode constants
// and the result-width helper used to size the counters.
package xnor_match_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_t;

  localparam logic MODE_XNOR = 1'b0;
  localparam logic MODE_XOR  = 1'b1;

  // Bits needed to represent every value in 0..max_val.
  function automatic int calc_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/xnor_match_acc_popcount_tree.sv
// popcount_tree: combinational population count of a WIDTH-bit word, built as
// a balanced binary adder tree over the leaves padded to a power of two.
module popcount_tree
  import xnor_match_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]                  bits,
  output logic [calc_width(WIDTH)-1:0]      count
);

  localparam int CW     = calc_width(WIDTH);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int LEAVES = 1 << LEVELS;
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap-ordered tree: leaves sit at LEAVES-1.., node i sums its two children.
  logic [CW-1:0] node [NODES];

  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      node[LEAVES-1+i] = CW'(bits[i]);
    end
    for (int i = LEAVES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    count = node[0];
  end

endmodule

// File: rtl/xnor_match_acc.sv
// xnor_match_acc: streaming XNOR/XOR popcount accumulator with one result per
// vector. Define XNOR_MATCH_BIPOLAR_EN to add the signed bipolar dot-product output.
module xnor_match_acc
  import xnor_match_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int ACC_W     = calc_width(WIDTH * MAX_BEATS),
  localparam int BEAT_W    = calc_width(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_last,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_ovf
`ifdef XNOR_MATCH_BIPOLAR_EN
  ,
  output logic signed [ACC_W:0] out_dot
`endif
);

  localparam int PC_W = calc_width(WIDTH);

  acc_state_t        state;
  acc_state_t        next_state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic              mode_q;
  logic [PC_W-1:0]   pc;
  logic              pc_valid;

  logic              accept;
  logic              first_beat;
  logic              at_limit;
  logic              vector_end;
  logic              forced_end;
  logic              release_result;
  logic              eff_mode;
  logic [WIDTH-1:0]  cmp_bits;
  logic [PC_W-1:0]   pc_next;

  assign accept         = in_valid && in_ready;
  assign first_beat     = (beat_cnt == '0);
  assign at_limit       = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
  assign vector_end     = accept && (in_last || at_limit);
  assign forced_end     = accept && !in_last && at_limit;
  assign release_result = (state == ST_HOLD) && out_ready;

  // The first beat uses the live mode input; later beats use the latched copy.
  assign eff_mode = first_beat ? mode : mode_q;
  assign cmp_bits = (eff_mode == MODE_XOR) ? (in_a ^ in_b) : ~(in_a ^ in_b);

  popcount_tree #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .bits  (cmp_bits),
    .count (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_ACC:   if (vector_end) next_state = ST_FLUSH;
      ST_FLUSH: next_state = ST_HOLD;
      ST_HOLD:  if (out_ready) next_state = ST_ACC;
      default:  next_state = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_HOLD);
  end

  // Stage 1: register the per-beat popcount and latch mode on a vector's first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      pc_valid <= 1'b0;
      mode_q   <= MODE_XNOR;
    end else begin
      pc_valid <= accept;
      if (accept) begin
        pc <= pc_next;
      end
      if (accept && first_beat) begin
        mode_q <= mode;
      end
    end
  end

  // Stage 2: accumulate; a released result clears the vector state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      ovf      <= 1'b0;
    end else if (release_result) begin
      acc      <= '0;
      beat_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (pc_valid) begin
        acc <= acc + ACC_W'(pc);
      end
      if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (forced_end) begin
        ovf <= 1'b1;
      end
    end
  end

  assign out_sum   = acc;
  assign out_beats = beat_cnt;
  assign out_ovf   = ovf;

`ifdef XNOR_MATCH_BIPOLAR_EN
  logic [ACC_W:0] two_sum;
  logic [ACC_W:0] width_beats;

  // Modular ACC_W+1-bit arithmetic; the true result always fits the signed range.
  assign two_sum     = {acc, 1'b0};
  assign width_beats = (ACC_W + 1)'(beat_cnt) * (ACC_W + 1)'(WIDTH);
  assign out_dot     = $signed(two_sum - width_beats);
`endif

endmodule

// File: tb/tb_xnor_match_acc.sv
// Self-checking bench for xnor_match_acc: directed scenarios plus randomized
// vectors scored against a beat-level reference model with a result queue.
module tb_xnor_match_acc;

  localparam int WIDTH  = 8;
  localparam int MB     = 4;
  localparam int ACC_W  = $clog2(WIDTH * MB + 1);
  localparam int BEAT_W = $clog2(MB + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic              in_last = 1'b0;
  logic              mode = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic [BEAT_W-1:0] out_beats;
  logic              out_ovf;
`ifdef XNOR_MATCH_BIPOLAR_EN
  logic signed [ACC_W:0] out_dot;
`endif

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  int m_cnt = 0;
  int m_sum = 0;
  bit m_mode = 1'b0;
  int exp_sum_q[$];
  int exp_beats_q[$];
  bit exp_ovf_q[$];

  xnor_match_acc #(
    .WIDTH     (WIDTH),
    .MAX_BEATS (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats),
    .out_ovf   (out_ovf)
`ifdef XNOR_MATCH_BIPOLAR_EN
    ,
    .out_dot   (out_dot)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference model: counts matches/mismatches per beat and closes a vector on
  // last or on the MB-th beat, queueing the expected result.
  task automatic modelBeat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic last, input logic m);
    int diff;
    if (m_cnt == 0) m_mode = m;
    diff = $countones(a ^ b);
    m_sum += m_mode ? diff : (WIDTH - diff);
    m_cnt++;
    if (last || m_cnt == MB) begin
      exp_sum_q.push_back(m_sum);
      exp_beats_q.push_back(m_cnt);
      exp_ovf_q.push_back(!last);
      m_cnt = 0;
      m_sum = 0;
    end
  endtask

  task automatic modelReset();
    m_cnt = 0;
    m_sum = 0;
    exp_sum_q.delete();
    exp_beats_q.delete();
    exp_ovf_q.delete();
  endtask

  // Presents one beat and holds it until accepted; returns cycles spent waiting.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic last, input logic m, output int tries);
    logic taken;
    taken = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    mode = m;
    while (!taken && tries < 64) begin
      @(negedge clk);
      taken = in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (taken) modelBeat(a, b, last, m);
    else checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = in_ready && (exp_sum_q.size() == 0);
    end
    if (!done) checkOutput("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every result handshake is compared against the model queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_sum_q.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        int es;
        int eb;
        bit eo;
        es = exp_sum_q.pop_front();
        eb = exp_beats_q.pop_front();
        eo = exp_ovf_q.pop_front();
        checkOutput("out_sum", longint'(out_sum), longint'(es));
        checkOutput("out_beats", longint'(out_beats), longint'(eb));
        checkOutput("out_ovf", longint'(out_ovf), longint'(eo));
`ifdef XNOR_MATCH_BIPOLAR_EN
        checkOutput("out_dot", longint'(out_dot), longint'(2 * es - WIDTH * eb));
`endif
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tries;
    bit seen;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rm;
    int len;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", longint'(in_ready), 1);
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_out_sum", longint'(out_sum), 0);
    checkOutput("rst_out_beats", longint'(out_beats), 0);
    checkOutput("rst_out_ovf", longint'(out_ovf), 0);
`ifdef XNOR_MATCH_BIPOLAR_EN
    checkOutput("rst_out_dot", longint'(out_dot), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single beat latency");
    out_ready = 1'b1;
    applyStimulus(8'hF0, 8'hF0, 1'b1, 1'b0, tries);
    checkOutput("flush_in_ready", longint'(in_ready), 0);
    checkOutput("flush_out_valid", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("hold_out_valid", longint'(out_valid), 1);
    checkOutput("hold_sum_8", longint'(out_sum), 8);
    @(posedge clk);
    #1;
    checkOutput("after_hold_in_ready", longint'(in_ready), 1);
    waitDrain();

    $display("[TB] three back-to-back beats");
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, tries);
    applyStimulus(8'hAA, 8'hAB, 1'b0, 1'b0, tries);
    checkOutput("b2b_beat2_tries", longint'(tries), 1);
    applyStimulus(8'h0F, 8'h0F, 1'b1, 1'b0, tries);
    checkOutput("b2b_beat3_tries", longint'(tries), 1);
    waitDrain();

    $display("[TB] xor mode and held mode");
    applyStimulus(8'hFF, 8'h0F, 1'b1, 1'b1, tries);
    waitDrain();
    applyStimulus(8'hFF, 8'h0F, 1'b0, 1'b1, tries);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, tries);
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(8'h3C, 8'h0F, 1'b1, 1'b0, tries);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checkOutput("bp_valid_seen", longint'(seen), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", longint'(out_valid), 1);
      checkOutput("bp_in_ready", longint'(in_ready), 0);
      if (exp_sum_q.size() != 0) begin
        checkOutput("bp_out_sum", longint'(out_sum), longint'(exp_sum_q[0]));
        checkOutput("bp_out_beats", longint'(out_beats), longint'(exp_beats_q[0]));
      end else begin
        checkOutput("bp_queue", 0, 1);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", longint'(in_ready), 1);
    out_ready = 1'b1;
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, tries);
    applyStimulus(8'h0F, 8'hF0, 1'b1, 1'b0, tries);
    waitDrain();

    $display("[TB] forced termination");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, tries);
      if (i == 4) checkOutput("beat5_stall_tries", longint'(tries), 3);
    end
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, tries);
    waitDrain();
    for (int i = 0; i < MB; i++) begin
      applyStimulus(8'hA5, 8'h5A, (i == MB - 1), 1'b1, tries);
    end
    waitDrain();

    $display("[TB] reset mid-vector");
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, tries);
    applyStimulus(8'h56, 8'h78, 1'b0, 1'b0, tries);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", longint'(out_valid), 0);
    checkOutput("async_rst_in_ready", longint'(in_ready), 1);
    checkOutput("async_rst_out_beats", longint'(out_beats), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, tries);
    waitDrain();

    $display("[TB] randomized vectors");
    rand_ready = 1'b1;
    for (int v = 0; v < 60; v++) begin
      len = $urandom_range(1, MB + 2);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        rm = 1'($urandom_range(0, 1));
        applyStimulus(ra, rb, (i == len - 1), rm, tries);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("queue_empty", longint'(exp_sum_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
